// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared types for the two-road traffic phase sequencer: phase codes,
// per-road lamp vector and the phase-to-duration lookup.
package traffic_pkg;

    typedef enum logic [2:0] {
        P_G1  = 3'b000,
        P_Y1  = 3'b001,
        P_AR1 = 3'b010,
        P_G2  = 3'b011,
        P_Y2  = 3'b100,
        P_AR2 = 3'b101
    } phaseT;

    typedef struct packed {
        logic g;
        logic y;
        logic r;
    } lampT;

    localparam lampT LAMP_G = 3'b100;
    localparam lampT LAMP_Y = 3'b010;
    localparam lampT LAMP_R = 3'b001;

    // Timer load value (duration minus one) for the phase being entered.
    function automatic int unsigned phase_duration(
        input phaseT       p,
        input int unsigned tGreen1,
        input int unsigned tGreen2,
        input int unsigned tYellow,
        input int unsigned tAllRed
    );
        case (p)
            P_G1:          return tGreen1 - 1;
            P_G2:          return tGreen2 - 1;
            P_Y1, P_Y2:    return tYellow - 1;
            P_AR1, P_AR2:  return tAllRed - 1;
            default:       return tGreen1 - 1;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_sequencer_phase_timer.sv
// Loadable saturating down-counter; zero_c flags an expired phase.
module phase_timer #(
    parameter int unsigned      TW        = 8,
    parameter logic [TW-1:0]    RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          load,
    input  logic [TW-1:0] loadVal,
    output logic          zero_c
);

    logic [TW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= loadVal;
        end else if (enable && (count != '0)) begin
            count <= count - TW'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-road phase sequencer: timed G/Y/all-red phases, latched side-road request,
// registered phase code and lamps. Optional emergency preempt via TRAFFIC_PREEMPT_EN.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned T_GREEN1 = 20,
    parameter int unsigned T_GREEN2 = 10,
    parameter int unsigned T_YELLOW = 4,
    parameter int unsigned T_ALLRED = 2,
    parameter int unsigned TW       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       req2,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic       preempt,
`endif
    output logic [2:0] C,
    output logic       G1,
    output logic       Y1,
    output logic       R1,
    output logic       G2,
    output logic       Y2,
    output logic       R2,
    output logic       req2_pend,
    output logic       phase_start
);

    localparam longint unsigned TMAX = 64'(1) << TW;

    if ((T_GREEN1 < 1) || (64'(T_GREEN1) > TMAX) ||
        (T_GREEN2 < 1) || (64'(T_GREEN2) > TMAX) ||
        (T_YELLOW < 1) || (64'(T_YELLOW) > TMAX) ||
        (T_ALLRED < 1) || (64'(T_ALLRED) > TMAX)) begin : gBadTiming
        $error("traffic_phase_sequencer: every T_* must be in 1..2**TW");
    end

    phaseT         phase;
    phaseT         nextPhase;
    phaseT         phaseNext;
    logic          advance;
    logic          timerZero;
    logic [TW-1:0] timerLoadVal;
    lampT          lamp1;
    lampT          lamp2;

    // Lamp pair {road1, road2} shown for a given phase.
    function automatic logic [5:0] lampsFor(input phaseT p);
        lampT r1;
        lampT r2;
        r1 = LAMP_R;
        r2 = LAMP_R;
        case (p)
            P_G1:    r1 = LAMP_G;
            P_Y1:    r1 = LAMP_Y;
            P_G2:    r2 = LAMP_G;
            P_Y2:    r2 = LAMP_Y;
            default: ;
        endcase
        return {r1, r2};
    endfunction

    // Successor phase and whether this enabled edge leaves the current phase.
    always_comb begin
        nextPhase = P_G1;
        advance   = 1'b0;
        case (phase)
            P_G1: begin
                nextPhase = P_Y1;
                advance   = timerZero && req2_pend;
`ifdef TRAFFIC_PREEMPT_EN
                if (preempt) advance = 1'b0;
`endif
            end
            P_Y1: begin
                nextPhase = P_AR1;
                advance   = timerZero;
            end
            P_AR1: begin
                nextPhase = P_G2;
                advance   = timerZero;
            end
            P_G2: begin
                nextPhase = P_Y2;
`ifdef TRAFFIC_PREEMPT_EN
                advance   = timerZero || preempt;
`else
                advance   = timerZero;
`endif
            end
            P_Y2: begin
                nextPhase = P_AR2;
                advance   = timerZero;
            end
            P_AR2: begin
                nextPhase = P_G1;
                advance   = timerZero;
            end
            default: begin
                nextPhase = P_G1;
                advance   = 1'b1;
            end
        endcase
        if (!enable) advance = 1'b0;
        phaseNext = advance ? nextPhase : phase;
    end

    assign timerLoadVal = TW'(phase_duration(nextPhase, T_GREEN1, T_GREEN2, T_YELLOW, T_ALLRED));

    phase_timer #(
        .TW        (TW),
        .RESET_VAL (TW'(T_GREEN1 - 1))
    ) uTimer (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .load    (advance),
        .loadVal (timerLoadVal),
        .zero_c  (timerZero)
    );

    // State, lamps and request latch all register off the next-state value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase       <= P_G1;
            lamp1       <= LAMP_G;
            lamp2       <= LAMP_R;
            req2_pend   <= 1'b0;
            phase_start <= 1'b1;
        end else begin
            phase          <= phaseNext;
            {lamp1, lamp2} <= lampsFor(phaseNext);
            phase_start    <= advance;
            // Entering side-road green consumes the request; a coincident req2 is dropped.
            if (advance && (nextPhase == P_G2)) begin
                req2_pend <= 1'b0;
            end else begin
                req2_pend <= req2_pend | req2;
            end
        end
    end

    assign C  = phase;
    assign G1 = lamp1.g;
    assign Y1 = lamp1.y;
    assign R1 = lamp1.r;
    assign G2 = lamp2.g;
    assign Y2 = lamp2.y;
    assign R2 = lamp2.r;

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
Clocked phase sequencer for a two-road intersection (road 1 = main/NS, road 2 = side/EW).
- Steps through timed green/yellow/all-red phases.
- Emits the 3-bit phase code {C2,C1,C0} consumed by the team's combinational light decoder, plus decoded lamp outputs for direct use.
- Side-road green is granted only on a latched vehicle request; main road rests in green otherwise.

Parameters:
- T_GREEN1, 20, minimum main-road green in cycles (>=1)
- T_GREEN2, 10, fixed side-road green in cycles (>=1)
- T_YELLOW, 4, yellow duration in cycles, both roads (>=1)
- T_ALLRED, 2, all-red clearance in cycles (>=1)
- TW, 8, timer width; every T_* must be <= 2^TW (elaboration-time check)

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = timer runs; 0 = freeze timer and state
- req2  in  1  side-road vehicle sensor, level, sampled each clk
- C  out  3  phase code {C2,C1,C0} to light decoder
- G1,Y1,R1  out  1 each  road-1 lamps, registered
- G2,Y2,R2  out  1 each  road-2 lamps, registered
- req2_pend  out  1  latched side-road request
- phase_start  out  1  one-cycle pulse on the first cycle of each new phase

Behaviour:
- States and codes: P_G1=000 (G1,R2), P_Y1=001 (Y1,R2), P_AR1=010 (R1,R2), P_G2=011 (R1,G2), P_Y2=100 (R1,Y2), P_AR2=101 (R1,R2). Codes 110/111 are never produced.
- Reset (async assert): state P_G1, C=000, G1=1, R2=1, all other lamps 0, req2_pend=0, phase_start=1, timer=T_GREEN1-1.
  - First posedge after reset deassert behaves as the 2nd cycle of P_G1.
- Timer:
  - Loaded with T_x-1 on phase entry; decrements each enabled cycle; saturates at 0.
  - Phase lasts exactly T_x enabled cycles, except P_G1 (see below).
- Transitions, evaluated only when enable=1:
  - P_G1 -> P_Y1 when timer==0 AND req2_pend==1; otherwise remain in P_G1 with timer held at 0 (rest state).
  - P_Y1 -> P_AR1 -> P_G2 -> P_Y2 -> P_AR2 -> P_G1, each on timer==0.
- req2_pend:
  - Set on any cycle with req2=1, including while enable=0.
  - Cleared on the cycle P_G2 is entered.
  - req2 asserted on the entry cycle of P_G2 is ignored; set wins in every other state.
  - Simultaneous set and exit: if req2 rises in the same cycle P_G1's timer reaches 0, the transition to P_Y1 occurs one cycle later, because the latch is registered.
- Outputs are registered from the next-state value, so lamps, C and state change on the same edge. Latency from the qualifying condition to new lamps is 1 clk.
- phase_start = 1 on the cycle after any state change; 0 otherwise, including while frozen.
- enable=0 holds state, timer, lamps and C; phase_start=0.
- Reset mid-phase: immediate return to the reset values above. Any pending request is lost.
- Invariant: never both G/Y active on road 1 and G/Y active on road 2; exactly one lamp per road is lit.

Optional Feature:
- Macro: TRAFFIC_PREEMPT_EN.
- When defined:
  - Adds input preempt (1 bit).
  - preempt=1 in P_G2 forces P_Y2 on the next enabled edge, loading T_YELLOW.
  - preempt=1 in P_G1 holds P_G1 regardless of req2_pend. req2_pend is retained.
  - preempt in any other state has no effect; the sequence continues normally.
- When undefined: no port, no logic. Behaviour is exactly as above.

Decomposition:
- Package traffic_pkg holds:
  - phase enum/localparams for the six codes with their 3-bit values
  - lamp-vector typedef {G,Y,R}
  - function phase_duration(phase) returning T_x-1
- One sub-module, phase_timer: loadable down-counter of width TW with enable, load and zero flag.
- The FSM and lamp decode stay in the top module.

Test Plan:
- Reset, no req2 for 100 cycles -> state stays P_G1, C=000, G1=1, R2=1, phase_start pulses only once after reset.
- req2 pulse 1 cycle at cycle 5, enable=1 -> P_Y1 entered at cycle 20. Then C = 001 (4 cycles), 010 (2), 011 (10), 100 (4), 101 (2), then back to 000. req2_pend clears on P_G2 entry.
- req2 held high continuously -> sequence repeats with period 20+4+2+10+4+2=42 cycles. Lamp exclusivity holds on every cycle.
- enable=0 for 7 cycles mid-P_G2 -> P_G2 lasts 17 wall cycles; C, lamps and timer frozen; phase_start=0 throughout the freeze.
- Reset asserted asynchronously mid-P_Y2 (between edges) -> outputs return to G1=1, R2=1, C=000 without waiting for clk; req2_pend=0.
- Under TRAFFIC_PREEMPT_EN: preempt at the 3rd cycle of P_G2 -> P_Y2 entered next edge. Then 4 cycles of Y2, 2 of all-red, then P_G1.
